// File: rtl/uart_tx_arbiter.sv
// Round-robin transmit arbiter: one byte FIFO per producer channel feeding a single UartTx,
// one byte per frame, paced by the tx_start / tx_busy handshake.
// state     | meaning
// IDLE      | waiting for tx_busy=0 and a non-empty FIFO
// START     | tx_start pulse on the wire, sdata held
// WAIT_BUSY | waiting for UartTx to raise tx_busy, 4-cycle time-out
// WAIT_DONE | frame in flight, waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        overflow,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        sdata,
  input  logic                     tx_busy,
  output logic [NUM_CH-1:0]        grant
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]       TMO_LOAD = 2'd3;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [NUM_CH-1:0] non_empty, push, pop, sel_onehot;
  logic [CH_W-1:0]   rr_ptr, sel, cand_c;
  logic              any_ne, launch;
  logic [1:0]        tmo;
  int                cand;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req_ready[i] = (count[i] != CNT_FULL);
      non_empty[i] = (count[i] != '0);
      push[i]      = req_valid[i] && req_ready[i];
    end
  end

  // Walk from the nearest-after-rr_ptr channel last, so the closest non-empty one wins.
  always_comb begin
    sel    = rr_ptr;
    any_ne = 1'b0;
    cand   = 0;
    cand_c = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_c = CH_W'(cand);
      if (non_empty[cand_c]) begin
        sel    = cand_c;
        any_ne = 1'b1;
      end
    end
  end

  assign launch = (state == IDLE) && !tx_busy && any_ne;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel_onehot[i] = (sel == CH_W'(i));
      pop[i]        = launch && sel_onehot[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (launch) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy || tmo == '0) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_ptr   <= CH_W'(NUM_CH - 1);
      tx_start <= 1'b0;
      sdata    <= '0;
      grant    <= '0;
      tmo      <= TMO_LOAD;
    end else begin
      state    <= state_nxt;
      tx_start <= launch;
      if (launch) begin
        sdata  <= mem[sel][rd_ptr[sel]];
        grant  <= sel_onehot;
        rr_ptr <= sel;
      end
      if (state == START) tmo <= TMO_LOAD;
      else if (state == WAIT_BUSY && tmo != '0) tmo <= tmo - 2'd1;
      if (state == WAIT_DONE && !tx_busy) grant <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      overflow <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (!push[i] && pop[i]) count[i] <= count[i] - CNT_W'(1);
        if (req_valid[i] && !req_ready[i]) overflow[i] <= 1'b1;
      end
    end
  end

  // Storage needs no reset; pointers and counts define what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= req_data[DATA_W*i +: DATA_W];
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized fill/drain rounds checked
// against a queue-based round-robin model, with a simple UartTx busy responder.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NUM_CH = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W = 8;

  logic                     clock = 1'b0;
  logic                     resetn = 1'b0;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH*DATA_W-1:0] req_data = '0;
  logic [NUM_CH-1:0]        req_ready, overflow, grant;
  logic                     tx_start;
  logic [DATA_W-1:0]        sdata;
  logic                     tx_busy = 1'b0;

  uart_tx_arbiter #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .overflow(overflow), .tx_start(tx_start), .sdata(sdata),
    .tx_busy(tx_busy), .grant(grant)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bmode = 0;      // 0 responds to tx_start, 1 holds busy high, 2 ties busy low
  int busy_dly = 1;
  int busy_len = 20;
  int dly = 0;
  int len = 0;
  int viol_busy = 0, viol_pulse = 0, viol_grant = 0;
  logic prev_start = 1'b0;
  logic [NUM_CH+DATA_W-1:0] cap_q[$];
  int cap_cyc[$];

  always @(posedge clock) begin
    #1;
    cyc++;
    if (tx_start === 1'b1) begin
      cap_q.push_back({grant, sdata});
      cap_cyc.push_back(cyc);
      if (tx_busy) viol_busy++;
      if (prev_start) viol_pulse++;
      if (!$onehot(grant)) viol_grant++;
    end
    prev_start = (tx_start === 1'b1);
  end

  always @(posedge clock) begin
    #2;
    if (bmode == 1) tx_busy = 1'b1;
    else if (bmode == 2) begin
      tx_busy = 1'b0;
      dly = 0;
      len = 0;
    end else begin
      if (tx_busy) begin
        if (len <= 1) tx_busy = 1'b0;
        else len--;
      end else if (dly != 0) begin
        dly--;
        if (dly == 0) begin
          tx_busy = 1'b1;
          len = busy_len;
        end
      end
      if (tx_start === 1'b1) dly = busy_dly;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0;
    tick(2);
    resetn = 1'b1;
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (cap_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, " frame count"}, 32'(cap_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((tx_busy || grant != '0) && k < 200) begin
      tick();
      k++;
    end
    check({tag, " idle"}, 32'({tx_busy, grant}), 32'(0));
  endtask

  task automatic expect_frame(input string tag, input int ch, input logic [DATA_W-1:0] b,
                              output int at);
    logic [NUM_CH+DATA_W-1:0] e;
    at = -1;
    if (cap_q.size() == 0) begin
      check({tag, " present"}, 32'(cap_q.size()), 32'(1));
      return;
    end
    e = cap_q.pop_front();
    at = cap_cyc.pop_front();
    check({tag, " grant"}, 32'(e[NUM_CH+DATA_W-1:DATA_W]), 32'(1) << ch);
    check({tag, " sdata"}, 32'(e[DATA_W-1:0]), 32'(b));
  endtask

  initial begin
    logic [DATA_W-1:0] mq [NUM_CH][$];
    logic [NUM_CH-1:0] ovf_exp;
    logic [DATA_W-1:0] b;
    int at0, at1, at2, k, v, last, remaining, ch;

    // reset state
    bmode = 0; busy_dly = 1; busy_len = 20;
    resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    check("rst tx_start", 32'(tx_start), 0);
    check("rst sdata", 32'(sdata), 0);
    check("rst grant", 32'(grant), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst req_ready", 32'(req_ready), 32'(2'b11));

    // single byte latency and pulse shape
    cap_q.delete(); cap_cyc.delete();
    req_data[7:0] = 8'hA5;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    check("t1 no start at push edge", 32'(tx_start), 0);
    tick();
    check("t1 start", 32'(tx_start), 1);
    check("t1 sdata", 32'(sdata), 32'h A5);
    check("t1 grant", 32'(grant), 1);
    tick();
    check("t1 pulse end", 32'(tx_start), 0);
    check("t1 grant in flight", 32'(grant), 1);
    k = 0;
    while (!tx_busy && k < 10) begin tick(); k++; end
    check("t1 busy rose", 32'(tx_busy), 1);
    k = 0;
    while (tx_busy && k < 40) begin tick(); k++; end
    check("t1 busy fell", 32'(tx_busy), 0);
    check("t1 grant before release", 32'(grant), 1);
    tick();
    check("t1 grant released", 32'(grant), 0);
    expect_frame("t1 frame", 0, 8'hA5, at0);
    check("t1 single pulse", 32'(cap_q.size()), 0);

    // round robin
    do_reset();
    cap_q.delete(); cap_cyc.delete();
    busy_len = 4;
    req_valid = 2'b11;
    req_data = {8'h20, 8'h10};
    tick();
    req_data = {8'h21, 8'h11};
    tick();
    req_valid = '0;
    wait_caps(4, 200, "t2");
    expect_frame("t2 f0", 0, 8'h10, at0);
    expect_frame("t2 f1", 1, 8'h20, at0);
    expect_frame("t2 f2", 0, 8'h11, at0);
    expect_frame("t2 f3", 1, 8'h21, at0);
    wait_idle("t2");

    // full FIFO and overflow
    do_reset();
    cap_q.delete(); cap_cyc.delete();
    bmode = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3 ready before push", 32'(req_ready[1]), 32'(i < 4));
      check("t3 overflow before push", 32'(overflow), 0);
      req_valid = 2'b10;
      req_data[15:8] = 8'(i + 1);
      tick();
    end
    req_valid = '0;
    check("t3 overflow sticky", 32'(overflow), 32'(2'b10));
    busy_dly = 2; busy_len = 3; bmode = 0;
    wait_caps(4, 200, "t3");
    for (int i = 0; i < 4; i++) expect_frame("t3 drain", 1, 8'(i + 1), at0);
    wait_idle("t3");
    tick(20);
    check("t3 fifth byte never sent", 32'(cap_q.size()), 0);

    // push exactly on the pop edge of a full FIFO
    do_reset();
    cap_q.delete(); cap_cyc.delete();
    bmode = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b01;
      req_data[7:0] = 8'(8'hC0 + i);
      tick();
    end
    req_valid = '0;
    busy_dly = 1; busy_len = 3; bmode = 0;
    tick();
    check("t4 full before pop", 32'(req_ready[0]), 0);
    check("t4 no start yet", 32'(tx_start), 0);
    req_valid = 2'b01;
    req_data[7:0] = 8'hE0;
    tick();
    check("t4 pop happened", 32'(tx_start), 1);
    check("t4 ready after pop", 32'(req_ready[0]), 1);
    check("t4 refused push flags overflow", 32'(overflow), 32'(2'b01));
    req_data[7:0] = 8'hE1;
    tick();
    req_valid = '0;
    check("t4 count back to full", 32'(req_ready[0]), 0);
    wait_caps(5, 300, "t4");
    for (int i = 0; i < 4; i++) expect_frame("t4 drain", 0, 8'(8'hC0 + i), at0);
    expect_frame("t4 retried byte", 0, 8'hE1, at0);
    wait_idle("t4");

    // busy time-out: START + 4 WAIT_BUSY + WAIT_DONE + IDLE = 7 cycles per frame
    do_reset();
    cap_q.delete(); cap_cyc.delete();
    bmode = 2;
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b10;
      req_data[15:8] = 8'(8'h31 + i);
      tick();
    end
    req_valid = '0;
    wait_caps(3, 100, "t5");
    expect_frame("t5 f0", 1, 8'h31, at0);
    expect_frame("t5 f1", 1, 8'h32, at1);
    expect_frame("t5 f2", 1, 8'h33, at2);
    check("t5 spacing 0-1", 32'(at1 - at0), 7);
    check("t5 spacing 1-2", 32'(at2 - at1), 7);

    // reset mid-frame
    do_reset();
    cap_q.delete(); cap_cyc.delete();
    bmode = 0; busy_dly = 1; busy_len = 20;
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b01;
      req_data[7:0] = 8'(8'h41 + i);
      tick();
    end
    req_valid = '0;
    k = 0;
    while (!tx_busy && k < 20) begin tick(); k++; end
    check("t6 frame in flight", 32'(tx_busy), 1);
    tick(2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("t6 tx_start", 32'(tx_start), 0);
    check("t6 sdata", 32'(sdata), 0);
    check("t6 grant", 32'(grant), 0);
    check("t6 overflow", 32'(overflow), 0);
    check("t6 req_ready", 32'(req_ready), 32'(2'b11));
    cap_q.delete(); cap_cyc.delete();
    tick(40);
    check("t6 queued bytes flushed", 32'(cap_q.size()), 0);
    req_valid = 2'b01;
    req_data[7:0] = 8'h77;
    tick();
    req_valid = '0;
    wait_caps(1, 50, "t6");
    expect_frame("t6 new byte", 0, 8'h77, at0);
    wait_idle("t6");

    // randomized fill-while-busy / drain rounds against the queue model
    do_reset();
    cap_q.delete(); cap_cyc.delete();
    last = NUM_CH - 1;
    ovf_exp = '0;
    for (int r = 0; r < 6; r++) begin
      bmode = 1;
      tick(2);
      for (int c = 0; c < 8; c++) begin
        for (int j = 0; j < NUM_CH; j++) begin
          check("rnd req_ready", 32'(req_ready[j]), 32'(mq[j].size() < FIFO_DEPTH));
          v = int'($urandom_range(0, 1));
          b = 8'($urandom);
          req_valid[j] = v[0];
          req_data[j*DATA_W +: DATA_W] = b;
          if (v != 0) begin
            if (mq[j].size() < FIFO_DEPTH) mq[j].push_back(b);
            else ovf_exp[j] = 1'b1;
          end
        end
        tick();
      end
      req_valid = '0;
      check("rnd overflow", 32'(overflow), 32'(ovf_exp));
      busy_dly = int'($urandom_range(1, 4));
      busy_len = int'($urandom_range(1, 8));
      bmode = 0;
      remaining = 0;
      for (int j = 0; j < NUM_CH; j++) remaining += mq[j].size();
      wait_caps(remaining, 400, "rnd");
      while (remaining > 0) begin
        ch = last;
        do ch = (ch + 1) % NUM_CH; while (mq[ch].size() == 0);
        b = mq[ch].pop_front();
        expect_frame("rnd frame", ch, b, at0);
        last = ch;
        remaining--;
      end
      wait_idle("rnd");
    end

    check("no tx_start while busy", 32'(viol_busy), 0);
    check("tx_start single cycle", 32'(viol_pulse), 0);
    check("grant one-hot at start", 32'(viol_grant), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
